// File: rtl/cbm2_busdecode_n.sv
// cbm2_busdecode_n: segment-15 I/O slot and colour RAM decoder with wait states and colour RAM erase
module cbm2_busdecode_n #(
    parameter int          NUM_IO   = 8,
    parameter logic [15:0] IO_BASE  = 16'hD800,
    parameter int          WS_W     = 2,
    parameter int          CRAM_AW  = 10,
    parameter logic [15:0] COL_BASE = 16'hD400
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   cpuReq,
    input  logic [7:0]             cpuSeg,
    input  logic [15:0]            cpuAddr,
    input  logic [7:0]             cpuDo,
    input  logic                   cpuWe,
    output logic                   cpuAck,
    output logic [7:0]             cpuDi,
    input  logic [NUM_IO-1:0]      ioEn,
    input  logic [NUM_IO*WS_W-1:0] ioWait,
    input  logic [NUM_IO*8-1:0]    ioData,
    output logic [NUM_IO-1:0]      ioCs,
    output logic                   ioWe,
    output logic [7:0]             ioDo,
    input  logic                   colErase,
    output logic                   colBusy
);
    typedef enum logic [1:0] {IDLE, ACCESS, STALL, ACK} state_t;
    state_t state, state_n;
    logic [NUM_IO-1:0] cs_hit, cs_l;
    logic [WS_W-1:0] wait_hit, cnt;
    logic [CRAM_AW-1:0] addr_l, ecnt;
    logic [7:0] io_sel;
    logic [3:0] cram [2**CRAM_AW];
    logic slot_hit, col_hit, is_col, we_l, erase_busy, start_erase, e6, done;
    int off;
    always_comb begin
        cs_hit = '0;
        wait_hit = '0;
        io_sel = '0;
        off = 0;
        // descending scan so the lowest matching slot is the one left standing
        for (int n = NUM_IO - 1; n >= 0; n--) begin
            off = int'(cpuAddr) - int'(IO_BASE) - n * 256;
            if (cpuSeg == 8'd15 && ioEn[n] && off >= 0 && off < 256) begin
                cs_hit = '0;
                cs_hit[n] = 1'b1;
                wait_hit = ioWait[n*WS_W +: WS_W];
            end
        end
        for (int n = 0; n < NUM_IO; n++)
            io_sel = io_sel | (cs_l[n] ? ioData[n*8 +: 8] : 8'h00);
    end
    assign slot_hit    = |cs_hit;
    assign col_hit     = cpuSeg == 8'd15 && cpuAddr[15:CRAM_AW] == COL_BASE[15:CRAM_AW];
    assign start_erase = colErase && !erase_busy;
    assign done        = state == ACCESS && cnt == '0;
    assign e6          = |((32'(ecnt) >> 6) & 32'd1);
    assign colBusy     = erase_busy;
    assign cpuAck      = state == ACK;
    assign ioCs        = state == ACCESS ? cs_l : '0;
    assign ioWe        = state == ACCESS && we_l;
    // a colour access must not race an erase that is running or about to start
    always_comb begin
        state_n = state == IDLE   ? (!cpuReq ? IDLE : slot_hit ? ACCESS : !col_hit ? ACK :
                                     (erase_busy || colErase) ? STALL : ACCESS) :
                  state == ACCESS ? (cnt == '0 ? ACK : ACCESS) :
                  state == STALL  ? ((erase_busy || colErase) ? STALL : ACCESS) :
                                    IDLE;
    end
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            cs_l       <= '0;
            is_col     <= 1'b0;
            we_l       <= 1'b0;
            addr_l     <= '0;
            cnt        <= '0;
            ioDo       <= 8'h00;
            cpuDi      <= 8'hFF;
            erase_busy <= 1'b0;
            ecnt       <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && cpuReq) begin
                cs_l   <= cs_hit;
                is_col <= !slot_hit && col_hit;
                we_l   <= cpuWe;
                addr_l <= cpuAddr[CRAM_AW-1:0];
                ioDo   <= cpuDo;
                cnt    <= slot_hit ? wait_hit : '0;
            end
            if (state == ACCESS && cnt != '0)
                cnt <= cnt - 1'b1;
            if (done && !we_l)
                cpuDi <= is_col ? {cpuDi[7:4], cram[addr_l]} : io_sel;
            if (start_erase) begin
                erase_busy <= 1'b1;
                ecnt       <= '0;
            end else if (erase_busy) begin
                erase_busy <= ecnt != '1;
                ecnt       <= ecnt == '1 ? ecnt : ecnt + 1'b1;
            end
        end
    end
    always_ff @(posedge clk_sys) begin
        if (!reset && erase_busy)
            cram[ecnt] <= {4{e6}};
        else if (!reset && done && is_col && we_l)
            cram[addr_l] <= ioDo[3:0];
    end
endmodule

// File: tb/tb_cbm2_busdecode_n.sv
// tb_cbm2_busdecode_n: scoreboard bench with a behavioural decode/colour RAM model and random traffic
module tb_cbm2_busdecode_n;
    localparam int IOB = 'hD800;
    logic clk_sys = 0, reset = 1, cpuReq = 0, cpuWe = 0, colErase = 0;
    logic [7:0] cpuSeg = 0, cpuDo = 0;
    logic [15:0] cpuAddr = 0;
    logic cpuAck, ioWe, colBusy;
    logic [7:0] cpuDi, ioCs, ioDo;
    logic [7:0] ioEn = 8'hFF;
    logic [15:0] ioWait = 0;
    logic [63:0] ioData = 0;
    typedef struct {logic [7:0] di; int lat; logic [7:0] cs; int cnt; logic we; logic [7:0] dout;} exp_t;
    exp_t q[$];
    int checks = 0, fails = 0, cyc = 0, n_busy;
    logic [7:0] di_m = 8'hFF;
    logic [3:0] cram_m [1024];
    logic [7:0] cs_seen = 0, do_seen = 0;
    logic we_seen = 0;
    int cs_cnt = 0;

    cbm2_busdecode_n dut (
        .clk_sys(clk_sys), .reset(reset), .cpuReq(cpuReq), .cpuSeg(cpuSeg), .cpuAddr(cpuAddr),
        .cpuDo(cpuDo), .cpuWe(cpuWe), .cpuAck(cpuAck), .cpuDi(cpuDi), .ioEn(ioEn), .ioWait(ioWait),
        .ioData(ioData), .ioCs(ioCs), .ioWe(ioWe), .ioDo(ioDo), .colErase(colErase), .colBusy(colBusy)
    );

    initial forever #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: slot windows are 256-byte pages above IO_BASE, colour RAM is $D400-$D7FF
    function automatic exp_t model(input logic [7:0] seg, input logic [15:0] addr, input logic we,
                                   input logic [7:0] dout, input logic stall, input int a);
        exp_t e;
        int slot = -1, w;
        for (int n = 0; n < 8; n++)
            if (slot < 0 && seg == 15 && ioEn[n] && int'(addr) >= IOB + n * 256 && int'(addr) < IOB + (n + 1) * 256)
                slot = n;
        e.we = we; e.dout = dout; e.cs = 0; e.cnt = 0;
        if (slot >= 0) begin
            w = int'(ioWait[slot*2 +: 2]);
            e.cs = 8'(1 << slot);
            e.cnt = w + 1;
            e.lat = a + 2 + w;
            if (!we) di_m = ioData[slot*8 +: 8];
        end else if (seg == 15 && addr >= 16'hD400 && addr < 16'hD800) begin
            e.lat = stall ? -1 : a + 2;
            if (we) cram_m[addr[9:0]] = dout[3:0];
            else di_m[3:0] = cram_m[addr[9:0]];
        end else
            e.lat = a + 1;
        e.di = di_m;
        return e;
    endfunction

    task automatic issue(input logic [7:0] seg, input logic [15:0] addr, input logic we,
                         input logic [7:0] dout, input logic stall);
        @(negedge clk_sys);
        cpuSeg = seg; cpuAddr = addr; cpuWe = we; cpuDo = dout; cpuReq = 1;
        q.push_back(model(seg, addr, we, dout, stall, cyc));
        @(negedge clk_sys);
        cpuReq = 0;
    endtask

    task automatic wait_idle;
        int n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(negedge clk_sys);
            n++;
        end
        if (q.size() != 0) begin
            checks++; fails++;
            $display("FAIL ack_timeout: %0d acks outstanding, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic erase(input logic poke, output int n);
        @(negedge clk_sys);
        colErase = 1;
        for (int k = 0; k < 1024; k++) cram_m[k] = (k & 64) != 0 ? 4'hF : 4'h0;
        @(negedge clk_sys);
        colErase = 0;
        n = 0;
        while (colBusy && n < 2000) begin
            n++;
            colErase = poke && n == 10;
            @(negedge clk_sys);
        end
        colErase = 0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk_sys);
            if (reset) begin
                cs_seen = 0; cs_cnt = 0;
            end else begin
                if (ioCs != 0) begin
                    cs_seen |= ioCs; cs_cnt++; we_seen = ioWe; do_seen = ioDo;
                end
                if (cpuAck) begin
                    if (q.size() == 0) chk("unexpected_ack", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("ack_di", cpuDi, e.di);
                        if (e.lat >= 0) chk("ack_latency", cyc, e.lat);
                        chk("cs_onehot", cs_seen, e.cs);
                        chk("cs_cycles", cs_cnt, e.cnt);
                        if (e.cnt > 0) chk("io_we", we_seen, e.we);
                        if (e.cnt > 0 && e.we) chk("io_do", do_seen, e.dout);
                    end
                    cs_seen = 0; cs_cnt = 0;
                end
            end
        end
    end

    initial begin
        logic [15:0] a;
        logic [7:0] s;
        int b;
        repeat (3) @(negedge clk_sys);
        reset = 0;
        @(negedge clk_sys);
        chk("reset_ack", cpuAck, 0);
        chk("reset_cs", ioCs, 0);
        chk("reset_iowe", ioWe, 0);
        chk("reset_iodo", ioDo, 0);
        chk("reset_di", cpuDi, 8'hFF);
        chk("reset_busy", colBusy, 0);
        erase(0, n_busy);
        chk("erase_len", n_busy, 1024);
        ioData[39:32] = 8'h5A; ioWait = 16'h0200;
        issue(15, 16'hDC05, 0, 0, 0); wait_idle;
        chk("slot4_read", cpuDi, 8'h5A);
        ioEn[3] = 0;
        issue(15, 16'hDB00, 0, 0, 0); wait_idle;
        chk("unmapped_hold", cpuDi, 8'h5A);
        ioEn = 8'hFF;
        issue(15, 16'hD412, 1, 8'h37, 0); wait_idle;
        issue(15, 16'hD412, 0, 0, 0); wait_idle;
        chk("col_read_d412", cpuDi, 8'h57);
        fork
            erase(1, n_busy);
            begin repeat (5) @(negedge clk_sys); issue(15, 16'hD440, 0, 0, 1); end
        join
        wait_idle;
        chk("erase_len_busy_poke", n_busy, 1024);
        chk("col_read_d440", cpuDi, 8'h5F);
        issue(15, 16'hD400, 0, 0, 0); wait_idle;
        chk("col_read_d400", cpuDi, 8'h50);
        // erase and a colour request together, then reset mid-erase
        @(negedge clk_sys);
        colErase = 1; cpuSeg = 15; cpuAddr = 16'hD440; cpuWe = 0; cpuReq = 1;
        @(negedge clk_sys);
        colErase = 0; cpuReq = 0;
        repeat (99) @(negedge clk_sys);
        chk("busy_mid_erase", colBusy, 1);
        reset = 1;
        repeat (2) @(negedge clk_sys);
        reset = 0;
        chk("abort_busy", colBusy, 0);
        chk("abort_di", cpuDi, 8'hFF);
        chk("abort_ack", cpuAck, 0);
        di_m = 8'hFF;
        repeat (10) @(negedge clk_sys);
        erase(0, n_busy);
        chk("erase_len_after_abort", n_busy, 1024);
        // request held high against a zero-wait slot
        ioWait = 0; ioData[23:16] = 8'hC3;
        @(negedge clk_sys);
        cpuSeg = 15; cpuAddr = 16'hDA10; cpuWe = 0; cpuReq = 1;
        for (int k = 0; k < 3; k++) q.push_back(model(15, 16'hDA10, 0, 0, 0, cyc + 3 * k));
        repeat (9) @(negedge clk_sys);
        cpuReq = 0;
        wait_idle;
        repeat (3) @(negedge clk_sys);
        for (int i = 0; i < 200; i++) begin
            ioEn = $urandom_range(0, 2) == 0 ? 8'($urandom) : 8'hFF;
            ioWait = 16'($urandom);
            ioData = {$urandom, $urandom};
            b = $urandom_range(0, 3);
            a = b < 2 ? 16'(IOB + $urandom_range(0, 2047)) : b == 2 ? 16'(16'hD400 + $urandom_range(0, 1023)) : 16'($urandom);
            s = $urandom_range(0, 4) == 0 ? 8'($urandom_range(0, 14)) : 8'd15;
            issue(s, a, 1'($urandom), 8'($urandom), 0);
            wait_idle;
        end
        repeat (5) @(negedge clk_sys);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/cbm2_busdecode_n.md
CBM2_BUSDECODE_N -- requirements
Module: cbm2_busdecode_n

Interface
REQ-001 Parameter NUM_IO, default 8: number of 256-byte I/O slots; range 1..8.
REQ-002 Parameter IO_BASE, default 16'hD800: segment-15 address of slot 0; slot n decodes IO_BASE+n*256.
REQ-003 Parameter WS_W, default 2: width of each per-slot wait-state count.
REQ-004 Parameter CRAM_AW, default 10: colour RAM address width, giving 2^CRAM_AW x 4-bit entries.
REQ-005 Parameter COL_BASE, default 16'hD400: segment-15 base of the colour RAM window; aligned to 2^CRAM_AW.
REQ-006 Clocking and reset: one clock, clk_sys; reset is synchronous and active-high; all state changes on the rising edge of clk_sys.
REQ-007 Port list (name, direction, width, meaning):
- clk_sys  in  1  system clock
- reset  in  1  synchronous active-high reset
- cpuReq  in  1  access request, sampled only in IDLE
- cpuSeg  in  8  segment number
- cpuAddr  in  16  address within segment
- cpuDo  in  8  write data
- cpuWe  in  1  write strobe
- cpuAck  out  1  one-cycle completion pulse
- cpuDi  out  8  registered read data
- ioEn  in  NUM_IO  per-slot enable
- ioWait  in  NUM_IO*WS_W  per-slot wait count, packed, slot 0 in the LSBs
- ioData  in  NUM_IO*8  per-slot read data, packed
- ioCs  out  NUM_IO  one-hot slot select
- ioWe  out  1  I/O write strobe
- ioDo  out  8  latched write data
- colErase  in  1  start colour RAM clear
- colBusy  out  1  clear in progress

Function
REQ-008 Requests are accepted only in IDLE; acceptance latches cpuSeg, cpuAddr, cpuDo and cpuWe. A request arriving outside IDLE is ignored and not queued.
REQ-009 Decode is performed on the latched values:
- slot n hit: seg==15, address in [IO_BASE+n*256, IO_BASE+n*256+255], and ioEn[n]=1
- colour hit: seg==15 and cpuAddr[15:CRAM_AW]==COL_BASE[15:CRAM_AW]
- anything else is unmapped
REQ-010 State machine has four states: IDLE, ACCESS, STALL, ACK.
- IDLE to ACCESS: on a slot or colour hit; the wait counter loads ioWait[slot], or 0 for colour.
- IDLE to ACK: on an unmapped request.
- IDLE to STALL: on a colour hit while colBusy=1.
REQ-011 In ACCESS, ioCs[slot] and ioWe=latched cpuWe are held. The counter decrements each cycle; at count 0 the block captures data and moves to ACK.
REQ-012 ACK lasts one cycle with cpuAck=1, then returns to IDLE; a cpuReq in that cycle is ignored.
REQ-013 Latency: request accepted at cycle 0 gives cpuAck at cycle 2+W for a slot with wait count W; an unmapped request gives cpuAck at cycle 1.
REQ-014 Read data: slot read loads cpuDi with the ioData byte of that slot. Colour read loads cpuDi[3:0] only and leaves cpuDi[7:4] unchanged. Writes and unmapped accesses leave cpuDi unchanged (open-bus hold).
REQ-015 Colour RAM write: latched cpuDo[3:0] is written on the ACCESS-to-ACK edge.
REQ-016 STALL: wait until colBusy=0, then go to ACCESS with wait count 0.
REQ-017 Erase is started by colErase=1 while not busy. Each cycle it writes entry k with {4{k[6]}} for k=0..2^CRAM_AW-1 in order. colBusy is high from the cycle after colErase through the last write.
REQ-018 colErase while busy is ignored.
REQ-019 colErase in the same cycle as a colour-hit cpuReq: erase starts and the CPU access enters STALL.
REQ-020 I/O slot accesses proceed normally during an erase.
REQ-021 The erase counter stops at its terminal value and does not wrap.
REQ-022 Slot decode overrides colour decode if the two windows overlap, and the lower slot index wins among slots.
REQ-023 ioCs is zero in every state other than ACCESS.

Reset
REQ-024 On reset the block enters IDLE with cpuAck=0, ioCs=0, ioWe=0, ioDo=0, cpuDi=8'hFF, colBusy=0 and the erase counter at 0. Reset during an erase aborts it and leaves colour RAM contents partially cleared. Reset during an access drops it with no cpuAck.

Verification
REQ-025 Read seg 15 $DC05, slot 4 ioWait=2, ioData byte4=8'h5A -> ioCs=8'h10 for 3 cycles, cpuAck at cycle 4, cpuDi=8'h5A.
REQ-026 Read seg 15 $DB00 with ioEn[3]=0, prior cpuDi=8'h5A -> cpuAck at cycle 1, cpuDi stays 8'h5A, ioCs=0 throughout.
REQ-027 Write 8'h37 to $D412, then read $D412 -> cpuDi=8'h57 (upper nibble kept from 8'h5A).
REQ-028 colErase, then after 5 cycles read $D440 -> STALL until colBusy falls after 1024 writes, then cpuDi[3:0]=4'hF. $D400 reads back 4'h0.
REQ-029 colErase and a colour-hit cpuReq asserted together, reset at erase count 100 -> after reset IDLE, colBusy=0, no cpuAck, cpuDi=8'hFF.
REQ-030 Back-to-back cpuReq held high against a slot with ioWait=0 -> cpuAck every 3 cycles, no request accepted in the ACK cycle.
